// File: rtl/round_ctrl_pkg.sv
// round_ctrl_pkg
//   Shared definitions for the round controller slice: default value width,
//   default starting lives, the controller state type and a small helper
//   that steps the lives count down without going below zero.
package round_ctrl_pkg;

  localparam int unsigned DEF_VAL_W      = 4;
  localparam int unsigned DEF_LIVES_INIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_GEN,
    ST_PLAY,
    ST_JUDGE,
    ST_FB_OK,
    ST_FB_BAD,
    ST_OVER
  } state_e;

  function automatic logic [1:0] lives_dec(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// round_ctrl_if
//   Link between the round controller and the number generator.
//   gen_enable : controller -> generator, rising edge requests a new number
//   gen_result : generator -> controller, the generated number
//   master modport is the controller side, slave modport the generator side.
interface round_ctrl_if
  import round_ctrl_pkg::*;
#(
  parameter int unsigned VAL_W = DEF_VAL_W
) ();

  logic             gen_enable;
  logic [VAL_W-1:0] gen_result;

  modport master (output gen_enable, input  gen_result);
  modport slave  (input  gen_enable, output gen_result);

endinterface

// File: rtl/round_ctrl_sec_timer.sv
// round_ctrl_sec_timer
//   Round timer: a tick prescaler that wraps every TICKS_PER_SEC enabled
//   cycles, and a seconds down-counter decremented on each wrap.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load secs with load_val_i and clear the prescaler
//   load_val_i   : seconds value to load
//   en_i         : advance the prescaler this cycle
//   secs_o       : seconds remaining
//   wrap_o       : prescaler wraps this cycle (combinational)
//   zero_o       : seconds counter is zero
module round_ctrl_sec_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] secs_o,
  output logic       wrap_o,
  output logic       zero_o
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    secs_q, secs_d;

  assign wrap_o = en_i && (tick_q == TW'(TICKS_PER_SEC - 1));

  always_comb begin
    tick_d = tick_q;
    secs_d = secs_q;
    if (load_i) begin
      tick_d = '0;
      secs_d = load_val_i;
    end else if (en_i) begin
      if (wrap_o) begin
        tick_d = '0;
        if (secs_q != '0) secs_d = secs_q - 4'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      secs_q <= '0;
    end else begin
      tick_q <= tick_d;
      secs_q <= secs_d;
    end
  end

  assign secs_o = secs_q;
  assign zero_o = (secs_q == '0);

endmodule

// File: rtl/round_ctrl.sv
// round_ctrl
//   Round controller for the binary number game. Requests a target from the
//   generator, runs a timed round, judges the player's guess, keeps score and
//   lives, and flags game over.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : one-cycle pulse, starts a game from IDLE or OVER
//   submit_i      : one-cycle pulse, commits guess_i (PLAY only)
//   guess_i       : player switch value
//   gen           : generator link (gen_enable out, gen_result in)
//   target_o      : latched target
//   score_o       : correct answers this game (saturating)
//   lives_o       : remaining lives
//   secs_left_o   : seconds remaining in the round
//   playing_o     : round in progress
//   ok_flash_o    : correct-answer feedback
//   bad_flash_o   : wrong/timeout feedback
//   game_over_o   : game finished
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int unsigned VAL_W         = DEF_VAL_W,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned LIVES_INIT    = DEF_LIVES_INIT,
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned ROUND_SECS    = 9,
  parameter int unsigned FB_TICKS      = 25000000,
  parameter int unsigned GEN_SETTLE    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               submit_i,
  input  logic [VAL_W-1:0]   guess_i,
  round_ctrl_if.master       gen,
  output logic [VAL_W-1:0]   target_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         lives_o,
  output logic [3:0]         secs_left_o,
  output logic               playing_o,
  output logic               ok_flash_o,
  output logic               bad_flash_o,
  output logic               game_over_o
);

  // One counter serves both the generator settle wait and the feedback hold;
  // the two states never overlap, and it restarts on every state change.
  localparam int unsigned CNT_MAX = (FB_TICKS > GEN_SETTLE) ? FB_TICKS : GEN_SETTLE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [VAL_W-1:0]   target_q, target_d;
  logic [VAL_W-1:0]   guess_q, guess_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;

  logic       tmr_load, tmr_en, tmr_wrap, tmr_zero;
  logic [3:0] secs;
  logic       settle_done, fb_done, timeout;

  assign settle_done = (cnt_q == CW'(GEN_SETTLE - 1));
  assign fb_done     = (cnt_q == CW'(FB_TICKS - 1));

  // The timer is frozen in a submit cycle so a coinciding timeout never fires:
  // the submitted guess is what gets judged.
  assign tmr_en   = (state_q == ST_PLAY) && !submit_i;
  assign tmr_load = (state_q == ST_WAIT_GEN) && settle_done;
  assign timeout  = (tmr_wrap && (secs == 4'd1)) || tmr_zero;

  round_ctrl_sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(4'(ROUND_SECS)),
    .en_i      (tmr_en),
    .secs_o    (secs),
    .wrap_o    (tmr_wrap),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    target_d = target_q;
    guess_d  = guess_q;
    score_d  = score_q;
    lives_d  = lives_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_i) begin
          score_d = '0;
          lives_d = 2'(LIVES_INIT);
          state_d = ST_REQ;
        end
      end
      ST_REQ:      state_d = ST_WAIT_GEN;
      ST_WAIT_GEN: begin
        if (settle_done) begin
          target_d = gen.gen_result;
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (submit_i) begin
          guess_d = guess_i;
          state_d = ST_JUDGE;
        end else if (timeout) begin
          lives_d = lives_dec(lives_q);
          state_d = ST_FB_BAD;
        end
      end
      ST_JUDGE: begin
        if (guess_q == target_q) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          state_d = ST_FB_OK;
        end else begin
          lives_d = lives_dec(lives_q);
          state_d = ST_FB_BAD;
        end
      end
      ST_FB_OK, ST_FB_BAD: begin
        if (fb_done) state_d = (lives_q == 2'd0) ? ST_OVER : ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      guess_q  <= '0;
      score_q  <= '0;
      lives_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      guess_q  <= guess_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
    end
  end

  assign gen.gen_enable = (state_q == ST_REQ);
  assign target_o       = target_q;
  assign score_o        = score_q;
  assign lives_o        = lives_q;
  assign secs_left_o    = secs;
  assign playing_o      = (state_q == ST_PLAY);
  assign ok_flash_o     = (state_q == ST_FB_OK);
  assign bad_flash_o    = (state_q == ST_FB_BAD);
  assign game_over_o    = (state_q == ST_OVER);

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl
//   Scoreboard bench for round_ctrl with small timing parameters. The driver
//   plays rounds (directed, then random) and pushes the expected verdict,
//   score and lives computed from the game rules; an independent monitor
//   compares them whenever the DUT starts showing feedback.
module tb_round_ctrl;

  localparam int VW = 4, SW = 8, LI = 3, TPS = 4, RS = 2, FBT = 3, GS = 2;
  localparam int PLAY_CYC = RS * TPS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          submit = 1'b0;
  logic [VW-1:0] guess = '0;
  logic [VW-1:0] target;
  logic [SW-1:0] score;
  logic [1:0]    lives;
  logic [3:0]    secs_left;
  logic          playing, ok_flash, bad_flash, game_over;

  round_ctrl_if #(.VAL_W(VW)) gif ();

  round_ctrl #(
    .VAL_W(VW), .SCORE_W(SW), .LIVES_INIT(LI), .TICKS_PER_SEC(TPS),
    .ROUND_SECS(RS), .FB_TICKS(FBT), .GEN_SETTLE(GS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .submit_i(submit),
    .guess_i(guess), .gen(gif), .target_o(target), .score_o(score),
    .lives_o(lives), .secs_left_o(secs_left), .playing_o(playing),
    .ok_flash_o(ok_flash), .bad_flash_o(bad_flash), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit ok;
    bit timeout;
    int score;
    int lives;
  } exp_t;

  exp_t exp_q[$];
  int   tgt_q[$];
  int   m_score, m_lives;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return gif.gen_enable;
      1:       return playing;
      2:       return ok_flash | bad_flash;
      default: return game_over;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    for (int i = 0; i < 60; i++) begin
      if (sig(which)) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_%s: got timeout expected signal high", name);
    finish_now();
  endtask

  task automatic new_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_gen_enable", gif.gen_enable, 1);
    check("start_score", score, 0);
    check("start_lives", lives, LI);
    check("start_game_over", game_over, 0);
    m_score = 0;
    m_lives = LI;
  endtask

  // action: 0 = submit guess g after dly play cycles, 1 = let it time out,
  //         2 = pull reset after dly play cycles
  task automatic play_round(input int tgt, input int action, input int dly, input int g);
    exp_t e;
    wait_for(0, "gen_enable");
    gif.gen_result = VW'(tgt);
    tgt_q.push_back(tgt);
    wait_for(1, "playing");
    if (action == 2) begin
      repeat (dly) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_target", target, 0);
      check("rst_score", score, 0);
      check("rst_lives", lives, 0);
      check("rst_secs", secs_left, 0);
      check("rst_flags", {playing, ok_flash, bad_flash, game_over, gif.gen_enable}, 0);
      check("rst_pending", exp_q.size(), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      return;
    end
    if (action == 0) begin
      repeat (dly) tick();
      guess  = VW'(g);
      submit = 1'b1;
      e.ok = (g == tgt);
      e.timeout = 1'b0;
      if (e.ok) m_score = (m_score == 255) ? 255 : m_score + 1;
      else      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      e.score = m_score;
      e.lives = m_lives;
      exp_q.push_back(e);
      tick();
      submit = 1'b0;
    end else begin
      e.ok = 1'b0;
      e.timeout = 1'b1;
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      e.score = m_score;
      e.lives = m_lives;
      exp_q.push_back(e);
    end
    wait_for(2, "flash");
    // submit and start during feedback must have no effect
    guess  = VW'(tgt);
    submit = 1'b1;
    start  = 1'b1;
    tick();
    submit = 1'b0;
    start  = 1'b0;
    if (m_lives == 0) wait_for(3, "game_over");
  endtask

  task automatic random_game();
    int tgt, act;
    new_game();
    for (int r = 0; r < 200 && m_lives > 0; r++) begin
      tgt = int'($urandom_range(0, 15));
      act = int'($urandom_range(0, 3));
      case (act)
        0: play_round(tgt, 0, int'($urandom_range(0, PLAY_CYC - 1)), tgt);
        1: play_round(tgt, 0, int'($urandom_range(0, PLAY_CYC - 1)),
                      (tgt + int'($urandom_range(1, 15))) % 16);
        2: play_round(tgt, 1, 0, 0);
        default: play_round(tgt, 0, PLAY_CYC - 1, int'($urandom_range(0, 15)));
      endcase
    end
  endtask

  // ---------------- monitor ----------------
  logic p_ge = 1'b0, p_play = 1'b0, p_fl = 1'b0;
  int   ge_len = 0, since_ge = 0, play_cyc = 0, fl_len = 0;
  exp_t cur = '{ok: 1'b0, timeout: 1'b0, score: 0, lives: 0};

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ge <= 1'b0; p_play <= 1'b0; p_fl <= 1'b0;
      ge_len = 0; since_ge = 0; play_cyc = 0; fl_len = 0;
    end else begin
      if (gif.gen_enable && !p_ge) begin
        ge_len   = 0;
        since_ge = 0;
      end else begin
        since_ge++;
      end
      if (gif.gen_enable) ge_len++;
      if (!gif.gen_enable && p_ge) check("gen_enable_width", ge_len, 1);

      if (playing && !p_play) begin
        check("settle_latency", since_ge, GS + 1);
        if (tgt_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL target: got round start expected no round");
        end else begin
          check("target", target, tgt_q.pop_front());
        end
        play_cyc = 0;
      end
      if (playing) begin
        check("secs_left", secs_left, RS - play_cyc / TPS);
        play_cyc++;
      end

      if ((ok_flash | bad_flash) && !p_fl) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL verdict: got feedback expected none");
        end else begin
          cur = exp_q.pop_front();
          check("ok_flash", ok_flash, cur.ok);
          check("bad_flash", bad_flash, !cur.ok);
          check("score", score, cur.score);
          check("lives", lives, cur.lives);
          if (cur.timeout) check("timeout_secs", secs_left, 0);
        end
        fl_len = 0;
      end
      if (ok_flash | bad_flash) fl_len++;
      if (!(ok_flash | bad_flash) && p_fl) begin
        check("flash_len", fl_len, FBT);
        check("game_over", game_over, cur.lives == 0);
      end

      p_ge   <= gif.gen_enable;
      p_play <= playing;
      p_fl   <= ok_flash | bad_flash;
    end
  end

  // ---------------- driver ----------------
  initial begin
    gif.gen_result = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_target", target, 0);
    check("reset_score", score, 0);
    check("reset_lives", lives, 0);
    check("reset_secs", secs_left, 0);
    check("reset_flags", {playing, ok_flash, bad_flash, game_over, gif.gen_enable}, 0);
    rst_n = 1'b1;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    check("idle_ignores_submit", {playing, gif.gen_enable}, 0);

    // directed game: correct, wrong, timeout, late correct, wrong -> over
    new_game();
    play_round(5, 0, 1, 5);
    play_round(5, 0, 2, 3);
    play_round(9, 1, 0, 0);
    play_round(12, 0, PLAY_CYC - 1, 12);
    play_round(7, 0, 0, 6);
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    check("over_ignores_submit", {game_over, gif.gen_enable}, 2'b10);

    // three consecutive wrong answers from a fresh game
    new_game();
    play_round(5, 0, 0, 3);
    play_round(15, 0, 3, 0);
    play_round(0, 0, PLAY_CYC - 1, 8);

    for (int gnum = 0; gnum < 3; gnum++) random_game();

    // reset in the middle of a round, then a full game afterwards
    new_game();
    play_round(int'($urandom_range(0, 15)), 2, 3, 0);
    random_game();

    repeat (10) tick();
    check("leftover_verdicts", exp_q.size(), 0);
    check("leftover_targets", tgt_q.size(), 0);
    finish_now();
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    n_bad++;
    finish_now();
  end

endmodule
